// File: rtl/imul_pkg.sv
// Shared types and widths for the iterative-multiplier issue controller.
package imul_pkg;

  localparam int IMUL_A_W       = 8;
  localparam int IMUL_B_W       = 32;
  localparam int IMUL_P_W       = 40;
  // Tag field in the FIFO entry is sized for the widest supported TAG_W.
  localparam int IMUL_TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } imul_state_e;

  typedef struct packed {
    logic [IMUL_TAG_MAX_W-1:0] tag;
    logic [IMUL_A_W-1:0]       a;
    logic [IMUL_B_W-1:0]       b;
  } imul_entry_t;

endpackage

// File: rtl/imul_opnd_fifo.sv
// Operand FIFO: DEPTH entries of W bits, pointers carry an extra wrap bit
// so full and empty are distinguished without a counter.
module imul_opnd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  assign dout_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/imul_issue_ctrl.sv
// Issue controller for the 8x32 iterative multiplier: buffers tagged requests,
// issues one at a time, holds the product for drain. IMUL_ISSUE_PERF_EN adds counters.
module imul_issue_ctrl
  import imul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [IMUL_A_W-1:0] in_a,
  input  logic [IMUL_B_W-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [IMUL_A_W-1:0] mul_a,
  output logic [IMUL_B_W-1:0] mul_b,
  output logic                mul_val_op,
  input  logic                mul_commit,
  input  logic [IMUL_P_W-1:0] mul_p,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [IMUL_P_W-1:0] out_p,
  output logic [TAG_W-1:0]    out_tag,
  output imul_state_e         dbg_state_o
`ifdef IMUL_ISSUE_PERF_EN
  ,
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_stall
`endif
);

  // Both interfaces: a transfer happens on a rising edge where valid && ready;
  // a producer keeps valid and data stable until that transfer.
  imul_state_e         state_q, state_d;
  imul_entry_t         push_entry, head_entry;
  logic                fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic                capture;
  logic [IMUL_A_W-1:0] mul_a_q;
  logic [IMUL_B_W-1:0] mul_b_q;
  logic [TAG_W-1:0]    tag_q, out_tag_q;
  logic [IMUL_P_W-1:0] out_p_q;
  logic                out_val_q;
  logic                unused_tag_hi;

  assign in_rdy     = reset && !fifo_full;
  assign fifo_push  = in_val && in_rdy;
  assign push_entry = '{tag: IMUL_TAG_MAX_W'(in_tag), a: in_a, b: in_b};
  assign unused_tag_hi = ^head_entry.tag;

  imul_opnd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(imul_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    mul_val_op = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending result blocks issue so only one product is ever in flight.
        if (!fifo_empty && !out_val_q) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_val_op = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_commit) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_q     <= '0;
      out_p_q   <= '0;
      out_tag_q <= '0;
      out_val_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        mul_a_q <= head_entry.a;
        mul_b_q <= head_entry.b;
        tag_q   <= head_entry.tag[TAG_W-1:0];
      end
      if (capture) begin
        out_p_q   <= mul_p;
        out_tag_q <= tag_q;
        out_val_q <= 1'b1;
      end else if (out_val_q && out_rdy) begin
        out_val_q <= 1'b0;
      end
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_val     = out_val_q;
  assign out_p       = out_p_q;
  assign out_tag     = out_tag_q;
  assign dbg_state_o = state_q;

`ifdef IMUL_ISSUE_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (mul_val_op)            perf_ops_q   <= perf_ops_q + 32'd1;
      if (out_val_q && !out_rdy) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_imul_issue_ctrl.sv
// Bench for imul_issue_ctrl: directed steps then random traffic, checked against
// a queue-based request/result model and an emulated multiplier with random latency.
module tb_imul_issue_ctrl;
  import imul_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_val = 1'b0;
  logic              in_rdy;
  logic [7:0]        in_a = '0;
  logic [31:0]       in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [7:0]        mul_a;
  logic [31:0]       mul_b;
  logic              mul_val_op;
  logic              mul_commit = 1'b0;
  logic [39:0]       mul_p = '0;
  logic              out_val;
  logic              out_rdy = 1'b1;
  logic [39:0]       out_p;
  logic [TAG_W-1:0]  out_tag;
  imul_state_e       dbg_state;
`ifdef IMUL_ISSUE_PERF_EN
  logic [31:0]       perf_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  imul_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_val_op  (mul_val_op),
    .mul_commit  (mul_commit),
    .mul_p       (mul_p),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_p       (out_p),
    .out_tag     (out_tag),
    .dbg_state_o (dbg_state)
`ifdef IMUL_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [7:0]       a;
    logic [31:0]      b;
  } req_t;

  req_t             pend_q[$];   // accepted, not yet issued
  req_t             res_q[$];    // issued, result not yet drained
  logic [TAG_W-1:0] got_tags[$];
  int               n_checks = 0, n_pass = 0, n_fail = 0;
  logic             awaiting = 1'b0, exp_ov = 1'b0, auto_mul = 1'b1, acc_now = 1'b0;
  int               lat_cnt = 0, ops_seen = 0, drained = 0;
  logic [39:0]      mp_hold = '0;
  logic [31:0]      exp_ops = '0, exp_stall = '0;

  function automatic logic [39:0] prod(input req_t e);
    return 40'(e.a) * 40'(e.b);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic rand_p();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    mul_p = r[39:0];
  endtask

  // One clock: log handshakes before the edge, then check outputs and run the multiplier.
  task automatic tick();
    logic commit_now, drain_now;
    req_t e;
    acc_now = in_val && in_rdy;
    if (acc_now) pend_q.push_back({in_tag, in_a, in_b});
    commit_now = mul_commit && awaiting;
    drain_now  = out_val && out_rdy;
    if (out_val && !out_rdy) exp_stall++;
    @(posedge clk);
    #1;
    mul_commit = 1'b0;
    rand_p();
    if (drain_now) begin
      if (res_q.size() > 0) begin
        got_tags.push_back(res_q[0].tag);
        void'(res_q.pop_front());
      end
      drained++;
    end
    if (commit_now) begin
      awaiting = 1'b0;
      exp_ov   = 1'b1;
    end else if (drain_now) begin
      exp_ov = 1'b0;
    end
    check("out_val", out_val, exp_ov);
    if (out_val && res_q.size() > 0) begin
      check("out_p", out_p, prod(res_q[0]));
      check("out_tag", out_tag, res_q[0].tag);
    end
    if (mul_val_op) begin
      ops_seen++;
      exp_ops++;
      check("op_while_result_pending", res_q.size(), 0);
      check("op_without_request", pend_q.size() > 0, 1);
      if (pend_q.size() > 0) begin
        e = pend_q.pop_front();
        check("mul_a", mul_a, e.a);
        check("mul_b", mul_b, e.b);
        res_q.push_back(e);
      end
      awaiting = 1'b1;
      lat_cnt  = $urandom_range(1, 4);
      mp_hold  = 40'(mul_a) * 40'(mul_b);
    end else if (awaiting) begin
      if (res_q.size() > 0) begin
        check("mul_a_hold", mul_a, res_q[0].a);
        check("mul_b_hold", mul_b, res_q[0].b);
      end
      if (lat_cnt > 1) lat_cnt--;
      else if (auto_mul) begin
        mul_commit = 1'b1;
        mul_p      = mp_hold;
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    in_val     = 1'b0;
    mul_commit = 1'b0;
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_val", out_val, 0);
    check("rst_val_op", mul_val_op, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_state", dbg_state, ST_IDLE);
    pend_q.delete();
    res_q.delete();
    awaiting  = 1'b0;
    exp_ov    = 1'b0;
    lat_cnt   = 0;
    exp_ops   = '0;
    exp_stall = '0;
    acc_now   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_in_rdy", in_rdy, 0);
    reset = 1'b1;
    #1;
    check("rst_release_in_rdy", in_rdy, 1);
  endtask

  task automatic push_req(input logic [7:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int g;
    in_val = 1'b1;
    in_a   = a;
    in_b   = b;
    in_tag = tag;
    g = 0;
    do begin
      tick();
      g++;
    end while (!acc_now && g < 20);
    check("push_accepted", acc_now, 1);
    in_val = 1'b0;
  endtask

  task automatic wait_out_val(input int max);
    int g;
    g = 0;
    while (!out_val && g < max) begin
      tick();
      g++;
    end
    check("wait_out_val", out_val, 1);
  endtask

  task automatic wait_idle(input int max);
    int g;
    g = 0;
    while ((pend_q.size() > 0 || res_q.size() > 0 || awaiting || out_val) && g < max) begin
      tick();
      g++;
    end
    check("wait_idle", g < max, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ops_before;
    int drained_before;
    logic [39:0] p0;

    #2;
    do_reset();

    // Single op with latency check
    out_rdy  = 1'b1;
    auto_mul = 1'b1;
    in_val = 1'b1; in_a = 8'h03; in_b = 32'h0000_0005; in_tag = 4'd1;
    tick();
    check("single_accept", acc_now, 1);
    in_val = 1'b0;
    check("single_pop_cycle_no_op", mul_val_op, 0);
    tick();
    check("single_issue", mul_val_op, 1);
    wait_out_val(20);
    check("single_p", out_p, 40'h00_0000_000F);
    check("single_tag", out_tag, 4'd1);
    wait_idle(20);

    // Max operands
    push_req(8'hFF, 32'hFFFF_FFFF, 4'd2);
    wait_out_val(20);
    check("max_p", out_p, 40'hFE_FFFF_FF01);
    check("max_tag", out_tag, 4'd2);
    wait_idle(20);

    // Fill FIFO with the multiplier stalled
    auto_mul = 1'b0;
    got_tags.delete();
    drained_before = drained;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1; in_a = 8'($urandom); in_b = $urandom; in_tag = TAG_W'(i);
      tick();
      check("fill_accept", acc_now, 1);
    end
    in_val = 1'b1; in_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      check("fill_full_rdy", in_rdy, 0);
      tick();
      check("fill_no_accept", acc_now, 0);
    end
    in_val   = 1'b0;
    auto_mul = 1'b1;
    begin
      int g;
      g = 0;
      while (drained < drained_before + 5 && g < 200) begin
        tick();
        g++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      logic [TAG_W-1:0] t;
      t = (i < got_tags.size()) ? got_tags[i] : 'x;
      check("fill_order", t, i);
    end
    check("fill_rdy_after", in_rdy, 1);

    // Result backpressure, with a spurious commit while the result is held
    out_rdy = 1'b0;
    push_req(8'h11, 32'h0000_0100, 4'd5);
    push_req(8'h22, 32'h0000_0003, 4'd6);
    wait_out_val(30);
    ops_before = ops_seen;
    p0 = out_p;
    check("bp_first_p", p0, 40'h00_0000_1100);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        mul_commit = 1'b1;
        mul_p      = 40'h12_3456_789A;
      end
      tick();
      check("bp_hold_p", out_p, p0);
    end
    check("bp_no_op", ops_seen, ops_before);
    out_rdy = 1'b1;
    tick();
    check("bp_gap1_no_op", mul_val_op, 0);
    tick();
    check("bp_gap2_op", mul_val_op, 1);
    wait_idle(30);

    // Spurious commit in IDLE with empty FIFO
    ops_before = ops_seen;
    mul_commit = 1'b1;
    rand_p();
    repeat (3) tick();
    check("spur_no_op", ops_seen, ops_before);
    check("spur_rdy", in_rdy, 1);
    push_req(8'h07, 32'h0000_0009, 4'd3);
    wait_out_val(20);
    check("spur_follow_p", out_p, 40'h00_0000_003F);
    wait_idle(20);

    // Reset while an op waits and two are queued
    auto_mul = 1'b0;
    push_req(8'h05, 32'h1, 4'd7);
    push_req(8'h06, 32'h2, 4'd8);
    push_req(8'h07, 32'h3, 4'd9);
    begin
      int g;
      g = 0;
      while (!awaiting && g < 20) begin
        tick();
        g++;
      end
      check("rw_reached_wait", awaiting, 1);
    end
    tick();
    do_reset();
    auto_mul   = 1'b1;
    ops_before = ops_seen;
    repeat (4) tick();
    check("rw_fifo_empty_no_op", ops_seen, ops_before);
    check("rw_rdy", in_rdy, 1);
    mul_commit = 1'b1;
    mul_p      = 40'hAB_CDEF_0123;
    tick();
    tick();
    check("rw_late_commit_ignored", out_val, 0);

    // Random traffic
    auto_mul = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_val || acc_now) begin
        in_val = ($urandom_range(0, 2) != 0);
        in_a   = 8'($urandom);
        in_b   = $urandom;
        in_tag = TAG_W'($urandom);
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      if (!awaiting && $urandom_range(0, 15) == 0) mul_commit = 1'b1;
      tick();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    wait_idle(300);

`ifdef IMUL_ISSUE_PERF_EN
    check("perf_ops", perf_ops, exp_ops);
    check("perf_stall", perf_stall, exp_stall);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
